// File: rtl/mcp9808_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcp9808_pkg
// Description : Shared MCP9808 definitions for the initiator and the bus-side
//               responder: register pointers, fixed address nibble, register
//               reset values and the responder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package mcp9808_pkg;

  // Fixed upper nibble of the 7-bit target address
  localparam logic [3:0] I2C_FADDR   = 4'b0011;

  // Register pointers
  localparam logic [3:0] RFU_REG     = 4'h0;
  localparam logic [3:0] CONFIG_REG  = 4'h1;
  localparam logic [3:0] TUPPER_REG  = 4'h2;
  localparam logic [3:0] TLOWER_REG  = 4'h3;
  localparam logic [3:0] TCRIT_REG   = 4'h4;
  localparam logic [3:0] TA_REG      = 4'h5;
  localparam logic [3:0] MANID_REG   = 4'h6;
  localparam logic [3:0] DEVID_REG   = 4'h7;
  localparam logic [3:0] RESOLTN_REG = 4'h8;

  // Register reset values (stored widths only)
  localparam logic [10:0] CONFIG_RST  = 11'h000;
  localparam logic [10:0] TLIMIT_RST  = 11'h000;
  localparam logic [1:0]  RESOLTN_RST = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } rsp_state_t;

  // Pointers that address a writable 16-bit register
  function automatic logic reg_is_word(input logic [3:0] p);
    return (p >= CONFIG_REG) && (p <= TCRIT_REG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Two-flop synchronizers for SCL/SDA plus single-cycle SCL
//               rise/fall and START/STOP condition pulses, all derived from
//               the synchronized levels.
// Ports       : clk, rst (sync, active-low)
//               scl_pin, sda_pin   raw bus inputs
//               sda                synchronized SDA level
//               scl_rise/scl_fall  one-clk SCL edge pulses
//               start/stop         one-clk bus condition pulses
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;

  // Reset to the idle bus level so no spurious edge follows reset release
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_pin};
      r_sda_sync <= {r_sda_sync[0], sda_pin};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  assign sda      = r_sda_sync[1];
  assign scl_rise =  r_scl_sync[1] & ~r_scl_d;
  assign scl_fall = ~r_scl_sync[1] &  r_scl_d;
  // SCL must be high before and after the SDA transition
  assign start    = r_scl_sync[1] & r_scl_d &  r_sda_d & ~r_sda_sync[1];
  assign stop     = r_scl_sync[1] & r_scl_d & ~r_sda_d &  r_sda_sync[1];

endmodule
`default_nettype wire

// File: rtl/mcp9808_responder.sv
`default_nettype none
// ============================================================================
// Module      : mcp9808_responder
// Description : I2C target emulating the MCP9808 register map. Decodes
//               address/pointer/write/read transfers, ACKs or NACKs, and
//               serves an ambient-temperature register built from tempSrc.
// Ports       : clk, rst (sync, active-low)
//               addressPins  low three address bits
//               SCL_i, SDA_i bus inputs; SDA_o (always 0), SDA_t (1 = release)
//               tempSrc      13-bit two's complement temperature, 1/16 degC
//               shutdown     CONFIG[8]; res RESOLUTION[1:0]
//               busy         addressed transfer in progress until STOP
// Revision    : 1.0 - initial release
// ============================================================================
module mcp9808_responder
  import mcp9808_pkg::*;
#(
  parameter logic [3:0]  ADDR_FIXED = I2C_FADDR,
  parameter logic [15:0] MAN_ID     = 16'h0054,
  parameter logic [15:0] DEV_ID     = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addressPins,
  input  logic        SCL_i,
  input  logic        SDA_i,
  output logic        SDA_o,
  output logic        SDA_t,
  input  logic [12:0] tempSrc,
  output logic        shutdown,
  output logic [1:0]  res,
  output logic        busy
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_pin  (SCL_i),
    .sda_pin  (SDA_i),
    .sda      (w_sda),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop)
  );

  rsp_state_t  r_state, w_state_nxt;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift_in;
  logic        r_ack_on;     // ACK states: low phase active; RDATA_ACK: master ACKed
  logic        r_rw;
  logic [3:0]  r_ptr;
  logic [1:0]  r_byte_idx;   // write byte index, saturates at 2
  logic [4:0]  r_msb;        // only the MSB bits that any register stores
  logic [15:0] r_tx;
  logic        r_rd_byte;    // 0 = first byte of the word being sent
  logic        r_sda_t;
  logic        r_busy;
  logic [10:0] r_cfg;
  logic [10:0] r_tupper, r_tlower, r_tcrit;
  logic [1:0]  r_res;
  logic [12:0] r_ta;

  logic        w_bit_last;
  logic [7:0]  w_byte;
  logic        w_addr_hit;
  logic        w_byte_fits;
  logic [15:0] w_rd_word;
  logic [2:0]  w_flags;
  logic signed [12:0] w_ta_s, w_upper_s, w_lower_s, w_crit_s;

  assign w_bit_last = (r_bitcnt == 3'd7);
  assign w_byte     = {r_shift_in[6:0], w_sda};
  assign w_addr_hit = (w_byte[7:1] == {ADDR_FIXED, addressPins});

  always_comb begin
    w_byte_fits = 1'b1;
    if (reg_is_word(r_ptr))
      w_byte_fits = (r_byte_idx != 2'd2);
    else if (r_ptr == RESOLTN_REG)
      w_byte_fits = (r_byte_idx == 2'd0);
  end

  // Limits are compared at full 13-bit scale with their two LSBs forced to 0
  assign w_ta_s    = r_ta;
  assign w_upper_s = {r_tupper, 2'b00};
  assign w_lower_s = {r_tlower, 2'b00};
  assign w_crit_s  = {r_tcrit,  2'b00};
  assign w_flags   = {w_ta_s >= w_crit_s, w_ta_s > w_upper_s, w_ta_s < w_lower_s};

  // 8-bit registers are left-justified so the second byte shifts out as 0x00
  always_comb begin
    w_rd_word = 16'h0000;
    case (r_ptr)
      CONFIG_REG:  w_rd_word = {5'b0, r_cfg};
      TUPPER_REG:  w_rd_word = {3'b0, r_tupper, 2'b00};
      TLOWER_REG:  w_rd_word = {3'b0, r_tlower, 2'b00};
      TCRIT_REG:   w_rd_word = {3'b0, r_tcrit,  2'b00};
      TA_REG:      w_rd_word = {w_flags, r_ta};
      MANID_REG:   w_rd_word = MAN_ID;
      DEVID_REG:   w_rd_word = DEV_ID;
      RESOLTN_REG: w_rd_word = {6'b0, r_res, 8'h00};
      default:     w_rd_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start)
      w_state_nxt = ST_ADDR;
    else if (w_stop)
      w_state_nxt = ST_IDLE;
    else begin
      case (r_state)
        ST_ADDR:      if (w_scl_rise && w_bit_last)
                        w_state_nxt = w_addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (w_scl_fall && r_ack_on)
                        w_state_nxt = r_rw ? ST_RDATA : ST_PTR;
        ST_PTR:       if (w_scl_rise && w_bit_last) w_state_nxt = ST_PTR_ACK;
        ST_PTR_ACK:   if (w_scl_fall && r_ack_on)   w_state_nxt = ST_WDATA;
        ST_WDATA:     if (w_scl_rise && w_bit_last)
                        w_state_nxt = w_byte_fits ? ST_WDATA_ACK : ST_IGNORE;
        ST_WDATA_ACK: if (w_scl_fall && r_ack_on)   w_state_nxt = ST_WDATA;
        ST_RDATA:     if (w_scl_rise && w_bit_last) w_state_nxt = ST_RDATA_ACK;
        ST_RDATA_ACK: begin
          if (w_scl_rise && w_sda)
            w_state_nxt = ST_IGNORE;
          else if (w_scl_fall && r_ack_on)
            w_state_nxt = ST_RDATA;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bitcnt   <= 3'd0;
      r_shift_in <= 8'h00;
      r_ack_on   <= 1'b0;
      r_rw       <= 1'b0;
      r_ptr      <= RFU_REG;
      r_byte_idx <= 2'd0;
      r_msb      <= 5'd0;
      r_tx       <= 16'h0000;
      r_rd_byte  <= 1'b0;
      r_sda_t    <= 1'b1;
      r_busy     <= 1'b0;
      r_cfg      <= CONFIG_RST;
      r_tupper   <= TLIMIT_RST;
      r_tlower   <= TLIMIT_RST;
      r_tcrit    <= TLIMIT_RST;
      r_res      <= RESOLTN_RST;
      r_ta       <= 13'd0;
    end else begin
      if (!r_cfg[8]) r_ta <= tempSrc;

      if (w_start) begin
        r_bitcnt <= 3'd0;
        r_ack_on <= 1'b0;
        r_sda_t  <= 1'b1;
      end else if (w_stop) begin
        r_ack_on <= 1'b0;
        r_sda_t  <= 1'b1;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift_in <= w_byte;
              r_bitcnt   <= r_bitcnt + 3'd1;
              if (w_bit_last) begin
                if (r_state == ST_ADDR) begin
                  r_rw <= w_byte[0];
                  if (w_addr_hit) r_busy <= 1'b1;
                end
                if (r_state == ST_PTR) r_ptr <= w_byte[3:0];
                if (r_state == ST_WDATA && r_byte_idx == 2'd0) r_msb <= w_byte[4:0];
              end
            end
          end

          // First fall after bit 8 pulls SDA low (and commits writes);
          // the following fall ends the ACK slot.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_ack_on <= 1'b1;
                r_sda_t  <= 1'b0;
                if (r_state == ST_WDATA_ACK) begin
                  if (reg_is_word(r_ptr) && r_byte_idx == 2'd1) begin
                    case (r_ptr)
                      CONFIG_REG: r_cfg    <= {r_msb[2:0], r_shift_in};
                      TUPPER_REG: r_tupper <= {r_msb, r_shift_in[7:2]};
                      TLOWER_REG: r_tlower <= {r_msb, r_shift_in[7:2]};
                      TCRIT_REG:  r_tcrit  <= {r_msb, r_shift_in[7:2]};
                      default: ;
                    endcase
                  end
                  if (r_ptr == RESOLTN_REG && r_byte_idx == 2'd0)
                    r_res <= r_shift_in[1:0];
                end
              end else begin
                r_ack_on <= 1'b0;
                r_sda_t  <= 1'b1;
                if (r_state == ST_ADDR_ACK && r_rw) begin
                  r_tx      <= w_rd_word;
                  r_sda_t   <= w_rd_word[15];
                  r_rd_byte <= 1'b0;
                end
                if (r_state == ST_PTR_ACK) r_byte_idx <= 2'd0;
                if (r_state == ST_WDATA_ACK && r_byte_idx != 2'd2)
                  r_byte_idx <= r_byte_idx + 2'd1;
              end
            end
          end

          ST_RDATA: begin
            if (w_scl_rise) r_bitcnt <= r_bitcnt + 3'd1;
            if (w_scl_fall) begin
              r_tx    <= {r_tx[14:0], 1'b0};
              r_sda_t <= r_tx[14];
            end
          end

          // Fall ending bit 8 releases SDA for the master; after an ACK the
          // next fall drives the next byte, reloading after a full word.
          ST_RDATA_ACK: begin
            if (w_scl_rise && !w_sda) r_ack_on <= 1'b1;
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_tx    <= {r_tx[14:0], 1'b0};
                r_sda_t <= 1'b1;
              end else begin
                r_ack_on  <= 1'b0;
                r_rd_byte <= ~r_rd_byte;
                if (r_rd_byte) begin
                  r_tx    <= w_rd_word;
                  r_sda_t <= w_rd_word[15];
                end else begin
                  r_sda_t <= r_tx[15];
                end
              end
            end
          end

          default: r_sda_t <= 1'b1;
        endcase
      end
    end
  end

  assign SDA_o    = 1'b0;
  assign SDA_t    = r_sda_t;
  assign busy     = r_busy;
  assign shutdown = r_cfg[8];
  assign res      = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mcp9808_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcp9808_responder
// Description : Directed bench for mcp9808_responder: bus-master tasks drive
//               address/pointer/write/read transfers on a wired-AND SDA and
//               compare against hand-computed register values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcp9808_responder;

  localparam int Q = 8;  // clk cycles per quarter SCL bit

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  addressPins = 3'd0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [12:0] tempSrc = 13'd0;
  logic        SDA_o, SDA_t, shutdown, busy;
  logic [1:0]  res;
  wire         sda_bus = sda_m & (SDA_t ? 1'b1 : SDA_o);

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;
  logic pulled = 1'b0;

  always #5 clk = ~clk;

  mcp9808_responder dut (
    .clk         (clk),
    .rst         (rst),
    .addressPins (addressPins),
    .SCL_i       (scl_m),
    .SDA_i       (sda_bus),
    .SDA_o       (SDA_o),
    .SDA_t       (SDA_t),
    .tempSrc     (tempSrc),
    .shutdown    (shutdown),
    .res         (res),
    .busy        (busy)
  );

  always @(negedge clk) if (mon_en && !SDA_t) pulled <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(Q);
      scl_m = 1'b1; tick(2 * Q);
      scl_m = 1'b0;
    end
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    nack = sda_bus;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_byte(input logic send_nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q); scl_m = 1'b1;
      tick(Q); b[i] = sda_bus;
      tick(Q); scl_m = 1'b0;
      tick(Q);
    end
    sda_m = send_nack; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1;
  endtask

  // Full 16-bit register write: address, pointer, MSB, LSB, STOP
  task automatic write_word(input string tag, input logic [3:0] ptr, input logic [15:0] val);
    logic [3:0] n;
    i2c_start;
    write_byte(8'h30, n[3]);
    write_byte({4'h0, ptr}, n[2]);
    write_byte(val[15:8], n[1]);
    write_byte(val[7:0], n[0]);
    i2c_stop;
    check(tag, {28'd0, n}, 32'd0);
  endtask

  task automatic set_ptr(input logic [3:0] ptr);
    logic n0, n1;
    i2c_start;
    write_byte(8'h30, n0);
    write_byte({4'h0, ptr}, n1);
    i2c_stop;
    check("ptr acks", {30'd0, n0, n1}, 32'd0);
  endtask

  task automatic read_word(output logic [15:0] w);
    logic n;
    i2c_start;
    write_byte(8'h31, n);
    check("rd addr ack", {31'd0, n}, 32'd0);
    read_byte(1'b0, w[15:8]);
    read_byte(1'b1, w[7:0]);
    i2c_stop;
  endtask

  initial begin
    logic        n;
    logic [15:0] w;
    logic [7:0]  b;

    rst = 1'b0; tick(5);
    rst = 1'b1; tick(5);
    check("rst SDA_t", {31'd0, SDA_t}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst shutdown", {31'd0, shutdown}, 32'd0);
    check("rst res", {30'd0, res}, 32'd3);

    // Address 0x0D is not ours (0x18)
    mon_en = 1'b1;
    i2c_start;
    write_byte(8'h1A, n);
    check("nack addr", {31'd0, n}, 32'd1);
    check("nack busy", {31'd0, busy}, 32'd0);
    i2c_stop;
    mon_en = 1'b0;
    check("nack SDA_t held", {31'd0, pulled}, 32'd0);

    // CONFIG = 0x0100 sets SHDN
    i2c_start;
    write_byte(8'h30, n); check("cfg ack0", {31'd0, n}, 32'd0);
    check("cfg busy", {31'd0, busy}, 32'd1);
    write_byte(8'h01, n); check("cfg ack1", {31'd0, n}, 32'd0);
    write_byte(8'h01, n); check("cfg ack2", {31'd0, n}, 32'd0);
    check("cfg shdn before lsb", {31'd0, shutdown}, 32'd0);
    write_byte(8'h00, n); check("cfg ack3", {31'd0, n}, 32'd0);
    check("cfg shutdown", {31'd0, shutdown}, 32'd1);
    i2c_stop;
    check("cfg busy after stop", {31'd0, busy}, 32'd0);

    // Clear SHDN, set T_CRIT = 80 C so only the upper flag fires at 26 C
    write_word("cfg clr acks", 4'h1, 16'h0000);
    check("cfg clr shutdown", {31'd0, shutdown}, 32'd0);
    write_word("tcrit acks", 4'h4, 16'h0500);
    write_word("tupper acks", 4'h2, 16'h0190);
    tempSrc = 13'h01A0;
    set_ptr(4'h5);
    read_word(w);
    check("temp flags", {16'd0, w}, 32'h41A0);
    check("temp release", {31'd0, SDA_t}, 32'd1);

    // Limits keep only bits [12:2]
    write_word("tlower acks", 4'h3, 16'hFFFF);
    read_word(w);
    check("tlower mask", {16'd0, w}, 32'h1FFC);

    // Shutdown freezes the temperature sample
    write_word("shdn acks", 4'h1, 16'h0100);
    tempSrc = 13'h0050;
    tick(4);
    set_ptr(4'h5);
    read_word(w);
    check("temp frozen", {16'd0, w}, 32'h41A0);

    // RESOLUTION: one data byte, a second is NACKed
    i2c_start;
    write_byte(8'h30, n);
    write_byte(8'h08, n);
    write_byte(8'h01, n); check("res ack", {31'd0, n}, 32'd0);
    check("res out", {30'd0, res}, 32'd1);
    write_byte(8'h55, n); check("res extra nack", {31'd0, n}, 32'd1);
    i2c_stop;
    check("res after nack", {30'd0, res}, 32'd1);
    i2c_start;
    write_byte(8'h31, n);
    read_byte(1'b1, b);
    i2c_stop;
    check("res readback", {24'd0, b}, 32'h01);

    // Pointer set then repeated START into a read of MANUFACTURER ID
    i2c_start;
    write_byte(8'h30, n);
    write_byte(8'h06, n);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
    write_byte(8'h31, n); check("rs addr ack", {31'd0, n}, 32'd0);
    read_byte(1'b0, w[15:8]);
    read_byte(1'b1, w[7:0]);
    i2c_stop;
    check("manid", {16'd0, w}, 32'h0054);

    // STOP after only the MSB of a T_CRIT write commits nothing
    i2c_start;
    write_byte(8'h30, n);
    write_byte(8'h04, n);
    write_byte(8'h12, n);
    i2c_stop;
    read_word(w);
    check("tcrit unchanged", {16'd0, w}, 32'h0500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
